// File: rtl/led_seq_pkg.sv
// -----------------------------------------------------------------------------
// led_seq_pkg
// Shared types for the LED pattern sequencer and its divider.
//
// Contents:
//   mode_e  - sequencer mode (ROT_R, ROT_L, BOUNCE, BLINK)
//   dir_e   - bounce direction (UP = toward MSB, DOWN = toward bit0)
//   MODE_W  - width of the mode field
//   SPEED_W - width of the speed (divider shift) field
//
// Optional feature macro used elsewhere in this slice: LED_SEQ_PWM_EN.
// -----------------------------------------------------------------------------
package led_seq_pkg;

  localparam int MODE_W  = 2;
  localparam int SPEED_W = 2;

  typedef enum logic [MODE_W-1:0] {
    ROT_R  = 2'd0,
    ROT_L  = 2'd1,
    BOUNCE = 2'd2,
    BLINK  = 2'd3
  } mode_e;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/led_seq_if.sv
// -----------------------------------------------------------------------------
// led_seq_if
// Control/status bundle between a controller (or board top) and led_seq.
//
// Signals:
//   en      - 1 = run, 0 = divider and pattern frozen
//   mode    - sequencer mode (mode_e)
//   speed   - divider shift, terminal count = DIV_FCTR >> speed
//   duty    - PWM brightness, PWM_W bits (only with LED_SEQ_PWM_EN)
//   led_out - LED drive, N_LED bits, active-high
//   tick    - one-cycle strobe in the first cycle showing a new pattern
//
// Modports:
//   master - drives en/mode/speed(/duty), observes led_out/tick
//   slave  - the sequencer side
//
// Optional feature macro: LED_SEQ_PWM_EN (adds duty and the PWM_W parameter).
// -----------------------------------------------------------------------------
interface led_seq_if
  import led_seq_pkg::*;
#(
  parameter int N_LED = 3
`ifdef LED_SEQ_PWM_EN
  ,
  parameter int PWM_W = 4
`endif
);

  logic               en;
  mode_e              mode;
  logic [SPEED_W-1:0] speed;
`ifdef LED_SEQ_PWM_EN
  logic [PWM_W-1:0]   duty;
`endif
  logic [N_LED-1:0]   led_out;
  logic               tick;

  modport master (
    output en,
    output mode,
    output speed,
`ifdef LED_SEQ_PWM_EN
    output duty,
`endif
    input  led_out,
    input  tick
  );

  modport slave (
    input  en,
    input  mode,
    input  speed,
`ifdef LED_SEQ_PWM_EN
    input  duty,
`endif
    output led_out,
    output tick
  );

endinterface

// File: rtl/led_seq_tick.sv
// -----------------------------------------------------------------------------
// led_seq_tick
// Clock-enable divider producing a single-cycle step pulse. Reusable wherever
// a slow strobe derived from the board clock is needed.
//
// Parameters:
//   DIV_FCTR - base terminal count; step period = (DIV_FCTR >> speed) + 1
//   CNT_W    - counter width, must hold DIV_FCTR
//
// Ports:
//   clk_in - board clock
//   rst    - synchronous active-high reset
//   en     - 1 = count, 0 = counter frozen and no step
//   speed  - runtime divider shift
//   step   - combinational, high in the cycle whose closing edge is a step
// -----------------------------------------------------------------------------
module led_seq_tick
  import led_seq_pkg::*;
#(
  parameter int DIV_FCTR = 24_000_000,
  parameter int CNT_W    = 25
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               en,
  input  logic [SPEED_W-1:0] speed,
  output logic               step
);

  localparam logic [CNT_W-1:0] DIV_VAL = CNT_W'(DIV_FCTR);

  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] limit;
  logic             at_limit;

  assign limit = DIV_VAL >> speed;

  // >= rather than == so that lowering speed mid-count past the new limit
  // steps on the next edge instead of running the counter all the way round.
  assign at_limit = (div_cnt >= limit);

  // Reset wins over a coincident step so the pattern never moves during rst.
  assign step = en && at_limit && !rst;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (en) begin
      if (at_limit) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_seq.sv
// -----------------------------------------------------------------------------
// led_seq
// Parametrised LED pattern sequencer: rotate right, rotate left, bounce and
// blink, advanced by an internal clock-enable divider with runtime speed.
//
// Parameters:
//   N_LED    - number of LED outputs (>= 1)
//   DIV_FCTR - base terminal count; step period = (DIV_FCTR >> speed) + 1
//   CNT_W    - divider counter width, must hold DIV_FCTR
//   PWM_W    - PWM counter width (only with LED_SEQ_PWM_EN)
//
// Ports:
//   clk_in - board clock, single clock domain
//   rst    - synchronous active-high reset
//   bus    - led_seq_if.slave: en, mode, speed, (duty), led_out, tick
//
// Optional feature macro: LED_SEQ_PWM_EN
//   Defined     - duty input, free-running pwm_cnt, registered gate on led_out
//   Not defined - led_out is the pattern register directly
// -----------------------------------------------------------------------------
module led_seq
  import led_seq_pkg::*;
#(
  parameter int N_LED    = 3,
  parameter int DIV_FCTR = 24_000_000,
  parameter int CNT_W    = 25
`ifdef LED_SEQ_PWM_EN
  ,
  parameter int PWM_W    = 4
`endif
) (
  input  logic    clk_in,
  input  logic    rst,
  led_seq_if.slave bus
);

  logic [N_LED-1:0] pattern;
  logic [N_LED-1:0] pattern_nxt;
  dir_e             dir;
  dir_e             dir_nxt;
  logic             tick_q;
  logic             step;

  led_seq_tick #(
    .DIV_FCTR (DIV_FCTR),
    .CNT_W    (CNT_W)
  ) u_tick (
    .clk_in (clk_in),
    .rst    (rst),
    .en     (bus.en),
    .speed  (bus.speed),
    .step   (step)
  );

  // Next pattern for the current mode. The one-hot modes first repair any
  // non-one-hot pattern (left behind by BLINK) back to bit0 heading UP.
  // A single LED has nowhere to move, so bounce simply holds it.
  always_comb begin
    pattern_nxt = pattern;
    dir_nxt     = dir;
    if (bus.mode == BLINK) begin
      pattern_nxt = (&pattern) ? '0 : '1;
    end else if (!$onehot(pattern)) begin
      pattern_nxt = N_LED'(1);
      dir_nxt     = UP;
    end else begin
      case (bus.mode)
        ROT_R: begin
          for (int i = 0; i < N_LED; i++) begin
            pattern_nxt[i] = pattern[(i + 1) % N_LED];
          end
        end
        ROT_L: begin
          for (int i = 0; i < N_LED; i++) begin
            pattern_nxt[i] = pattern[(i + N_LED - 1) % N_LED];
          end
        end
        BOUNCE: begin
          if (N_LED > 1) begin
            // Turn around at an end within the same step: no dwell.
            if (dir == UP) begin
              if (pattern[N_LED-1]) begin
                dir_nxt     = DOWN;
                pattern_nxt = pattern >> 1;
              end else begin
                pattern_nxt = pattern << 1;
              end
            end else begin
              if (pattern[0]) begin
                dir_nxt     = UP;
                pattern_nxt = pattern << 1;
              end else begin
                pattern_nxt = pattern >> 1;
              end
            end
          end
        end
        default: begin
          pattern_nxt = pattern;
        end
      endcase
    end
  end

  // Pattern, direction and the tick strobe. tick is the registered step, so
  // it is high in exactly the cycle the new pattern first appears.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      pattern <= N_LED'(1);
      dir     <= UP;
      tick_q  <= 1'b0;
    end else begin
      tick_q <= step;
      if (step) begin
        pattern <= pattern_nxt;
        dir     <= dir_nxt;
      end
    end
  end

  assign bus.tick = tick_q;

`ifdef LED_SEQ_PWM_EN
  logic [PWM_W-1:0] pwm_cnt;
  logic             gate_q;

  // pwm_cnt runs regardless of en so a paused pattern keeps its brightness.
  // Full-scale duty forces the gate on, otherwise 15/16 would be the maximum.
  // The gate is registered so led_out is a plain AND of two flops.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      pwm_cnt <= '0;
      gate_q  <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      gate_q  <= (&bus.duty) || (pwm_cnt < bus.duty);
    end
  end

  assign bus.led_out = pattern & {N_LED{gate_q}};
`else
  assign bus.led_out = pattern;
`endif

endmodule

// File: tb/tb_led_seq.sv
// -----------------------------------------------------------------------------
// tb_led_seq
// Directed self-checking bench for led_seq with DIV_FCTR=4 (step every 5
// cycles at speed 0). A 3-LED instance covers rotate, blink, mode-entry
// repair, en hold, speed change and mid-count reset; a 4-LED instance runs
// BOUNCE alongside it for the first seven steps.
// With LED_SEQ_PWM_EN defined, duty is held at full scale during the pattern
// checks and a final section measures the gate for duty 4, 0 and 15.
// -----------------------------------------------------------------------------
module tb_led_seq;
  import led_seq_pkg::*;

  logic clk_in = 1'b0;
  logic rst;

  always #5 clk_in = ~clk_in;

  led_seq_if #(.N_LED(3)) bus3 ();
  led_seq_if #(.N_LED(4)) bus4 ();

  led_seq #(
    .N_LED    (3),
    .DIV_FCTR (4),
    .CNT_W    (8)
  ) dut3 (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus3)
  );

  led_seq #(
    .N_LED    (4),
    .DIV_FCTR (4),
    .CNT_W    (8)
  ) dut4 (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus4)
  );

`ifdef LED_SEQ_PWM_EN
  localparam logic [2:0] RST3 = 3'b000;
  localparam logic [3:0] RST4 = 4'b0000;
`else
  localparam logic [2:0] RST3 = 3'b001;
  localparam logic [3:0] RST4 = 4'b0001;
`endif

  int         testsRun    = 0;
  int         testsFailed = 0;
  logic [2:0] cur3;
  logic [3:0] cur4;
  logic       check4;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic rstV, input logic enV,
                               input mode_e modeV, input logic [1:0] speedV);
    rst        = rstV;
    bus3.en    = enV;
    bus3.mode  = modeV;
    bus3.speed = speedV;
  endtask

  // n cycles in which nothing may change and no tick may appear.
  task automatic idleCheck(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      cycle();
      checkOutput({tag, " hold3"}, 32'(bus3.led_out), 32'(cur3));
      checkOutput({tag, " tick3"}, 32'(bus3.tick), 32'(0));
      if (check4) begin
        checkOutput({tag, " hold4"}, 32'(bus4.led_out), 32'(cur4));
        checkOutput({tag, " tick4"}, 32'(bus4.tick), 32'(0));
      end
    end
  endtask

  // nWait quiet cycles, then one cycle that must show the new pattern + tick.
  task automatic stepCheck(input string tag, input int nWait,
                           input logic [2:0] exp3, input logic [3:0] exp4);
    idleCheck(tag, nWait);
    cycle();
    checkOutput({tag, " led3"}, 32'(bus3.led_out), 32'(exp3));
    checkOutput({tag, " step3"}, 32'(bus3.tick), 32'(1));
    cur3 = exp3;
    if (check4) begin
      checkOutput({tag, " led4"}, 32'(bus4.led_out), 32'(exp4));
      checkOutput({tag, " step4"}, 32'(bus4.tick), 32'(1));
      cur4 = exp4;
    end
  endtask

`ifdef LED_SEQ_PWM_EN
  task automatic pwmCheck(input string tag, input logic [3:0] dutyV,
                          input int expOn);
    int onCount;
    bus3.duty = dutyV;
    cycle();
    cycle();
    onCount = 0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      if (bus3.led_out != 3'b000) onCount++;
    end
    checkOutput(tag, 32'(onCount), 32'(expOn));
  endtask
`endif

  initial begin
`ifdef LED_SEQ_PWM_EN
    bus3.duty = 4'hF;
    bus4.duty = 4'hF;
`endif
    applyStimulus(1'b1, 1'b0, ROT_R, 2'd0);
    bus4.en    = 1'b0;
    bus4.mode  = BOUNCE;
    bus4.speed = 2'd0;
    check4     = 1'b1;
    cycle();
    cycle();
    checkOutput("reset led3", 32'(bus3.led_out), 32'(RST3));
    checkOutput("reset tick3", 32'(bus3.tick), 32'(0));
    checkOutput("reset led4", 32'(bus4.led_out), 32'(RST4));
    checkOutput("reset tick4", 32'(bus4.tick), 32'(0));

    applyStimulus(1'b0, 1'b1, ROT_R, 2'd0);
    bus4.en = 1'b1;
    cur3    = 3'b001;
    cur4    = 4'b0001;

    stepCheck("rotr1", 4, 3'b100, 4'b0010);
    stepCheck("rotr2", 4, 3'b010, 4'b0100);
    stepCheck("rotr3", 4, 3'b001, 4'b1000);

    bus3.mode = BLINK;
    stepCheck("blink1", 4, 3'b111, 4'b0100);
    stepCheck("blink2", 4, 3'b000, 4'b0010);

    bus3.mode = ROT_L;
    stepCheck("rotl1", 4, 3'b001, 4'b0001);
    stepCheck("rotl2", 4, 3'b010, 4'b0010);

    bus4.en = 1'b0;
    check4  = 1'b0;

    bus3.en = 1'b0;
    idleCheck("en0", 20);

    bus3.en = 1'b1;
    idleCheck("pre", 3);
    bus3.speed = 2'd2;
    stepCheck("spd1", 0, 3'b100, 4'b0000);
    stepCheck("spd2", 1, 3'b001, 4'b0000);
    stepCheck("spd3", 1, 3'b010, 4'b0000);

    bus3.speed = 2'd0;
    idleCheck("mid", 2);
    rst = 1'b1;
    cycle();
    checkOutput("midrst led3", 32'(bus3.led_out), 32'(RST3));
    checkOutput("midrst tick3", 32'(bus3.tick), 32'(0));
    rst  = 1'b0;
    cur3 = 3'b001;
    stepCheck("post", 4, 3'b010, 4'b0000);

`ifdef LED_SEQ_PWM_EN
    bus3.en = 1'b0;
    pwmCheck("pwm duty4", 4'd4, 4);
    pwmCheck("pwm duty0", 4'd0, 0);
    pwmCheck("pwm duty15", 4'd15, 16);
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/led_seq.md
Name: led_seq

Overview:
- Parametrised LED pattern sequencer for N_LED outputs; successor to the fixed 3-LED rotator.
- Internal clock-enable divider with runtime speed select; four runtime modes: rotate right, rotate left, bounce, blink.
- Emits a one-cycle step strobe for other blocks. Sits directly on the board LED pins; the only clock is the board oscillator.

Parameters:
- N_LED, 3, number of LED outputs (>=1).
- DIV_FCTR, 24_000_000, base terminal count; step period = (DIV_FCTR>>speed)+1 cycles.
- CNT_W, 25, divider counter width; must hold DIV_FCTR.
- PWM_W, 4, duty/PWM counter width (used only with LED_SEQ_PWM_EN).

Ports:
- clk_in, input, 1, board clock; single clock domain.
- rst, input, 1, reset; synchronous, active-high.
- en, input, 1, 1 = run; 0 = divider and pattern frozen.
- mode, input, 2, 00 ROT_R, 01 ROT_L, 10 BOUNCE, 11 BLINK.
- speed, input, 2, divider shift; terminal count LIMIT = DIV_FCTR>>speed.
- duty, input, PWM_W, brightness (present only with LED_SEQ_PWM_EN).
- led_out, output, N_LED, LED drive, active-high.
- tick, output, 1, one-cycle strobe, high in the first cycle showing a new pattern.

Behaviour:
- Reset, on a clk_in edge with rst=1:
  - div_cnt=0, pattern=1 (bit0 only), dir=UP, tick=0.
  - led_out=1 (PWM: led_out=0 until the gate is computed; pwm_cnt=0).
  - rst overrides en and any step in the same cycle. Reset mid-step discards the step.
- Divider:
  - With en=1, div_cnt increments each cycle.
  - At the edge where div_cnt>=LIMIT: div_cnt<=0, a step occurs, and tick<=1 for exactly one cycle.
  - The >= comparison keeps a speed change mid-count from running to 2^CNT_W; the next step then occurs on the next edge.
  - With en=0, div_cnt, pattern, dir and led_out hold; tick=0.
- mode and speed are sampled combinationally. mode only takes effect at a step edge.
- Step actions by mode:
  - ROT_R: pattern <= {pattern[0], pattern[N-1:1]}. Example, N=3: 001 -> 100 -> 010 -> 001.
  - ROT_L: pattern <= {pattern[N-2:0], pattern[N-1]}.
  - BOUNCE: one-hot moves toward the MSB when dir=UP, toward bit0 when dir=DOWN.
    - At bit N-1 with UP: dir<=DOWN and move down in the same step. Mirror behaviour at bit0.
    - No dwell at either end; period 2N-2 steps. N=3: 001,010,100,010,001...
  - BLINK: if pattern is all-ones -> all-zeros, else -> all-ones.
- Mode-entry repair, applied at the step:
  - If mode is ROT_R, ROT_L or BOUNCE and pattern is not exactly one-hot (e.g. after BLINK), pattern<=1 and dir<=UP instead of the normal move.
  - Any one-hot pattern continues from its current position.
  - Switching between BOUNCE and rotate keeps position; dir is used only by BOUNCE.
- N_LED=1: rotate and bounce hold 1; BLINK toggles 1/0.
- Without PWM, led_out = pattern, registered; tick is coincident with the new value.

Optional Feature:
- Macro: LED_SEQ_PWM_EN.
- Defined:
  - duty port exists; pwm_cnt (PWM_W bits) free-runs every cycle regardless of en.
  - gate_q <= (duty == all-ones) || (pwm_cnt < duty).
  - led_out = pattern & {N_LED{gate_q}}. duty=0 gives fully off; all-ones gives fully on.
  - Registered gate, so led_out is glitch-free; one-cycle gate lag is permitted.
- Not defined: no duty port, no pwm_cnt, led_out = pattern.

Decomposition:
- Package led_seq_pkg:
  - mode enum: ROT_R=2'd0, ROT_L=2'd1, BOUNCE=2'd2, BLINK=2'd3.
  - dir enum: UP, DOWN.
- Sub-module led_seq_tick:
  - Holds the divider counter, LIMIT shift, en gating and >= terminal logic.
  - Outputs a one-cycle step pulse.
  - Reusable by other board examples needing slow strobes.
- Top holds the pattern/dir registers and the optional PWM gate.

Test Plan (sim with DIV_FCTR=4, N_LED=3, speed=0 unless stated):
- Reset then ROT_R: led_out 001 -> 100 -> 010 -> 001. Each change every 5 cycles; tick high exactly one cycle per change.
- BOUNCE, N_LED=4: sequence 0001,0010,0100,1000,0100,0010,0001,0010.
- BLINK for 2 steps (111, 000), then ROT_L: next step -> 001, then 010. en=0 for 20 cycles: no change, tick stays 0.
- speed: set speed=2 (LIMIT=1) while div_cnt=3. Step on the next edge, then period 2 cycles; rst asserted mid-count returns led_out=001, div_cnt=0.
- PWM (LED_SEQ_PWM_EN, PWM_W=4):
  - duty=4: gate high 4 of every 16 cycles.
  - duty=0: led_out=0 always.
  - duty=15: led_out=pattern continuously.
